// File: rtl/lfc_pkg.sv
// lfc_pkg: shared types and constants for the line-following controller
package lfc_pkg;
  typedef enum logic [2:0] {IDLE, FOLLOW, NODE, TURN, LOST, STOP} state_t;
  typedef enum logic {W = 1'b0, B = 1'b1} cls_t;
  localparam logic [1:0] T_STRAIGHT = 2'd0;
  localparam logic [1:0] T_RIGHT    = 2'd1;
  localparam logic [1:0] T_UTURN    = 2'd2;
  localparam logic [1:0] T_LEFT     = 2'd3;
  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [2:0] CLS_WBW = {W, B, W};
  localparam logic [2:0] CLS_BBB = {B, B, B};
endpackage

// File: rtl/line_follow_ctrl_if.sv
// line_follow_ctrl_if: sensor, planner and motor signals of the line-following controller
interface line_follow_ctrl_if #(
  parameter int ADC_W = 12,
  parameter int DC_W  = 5
);
  logic             enable;
  logic [ADC_W-1:0] left, middle, right;
  logic             sample_valid;
  logic [1:0]       turn_cmd;
  logic             turn_valid;
  logic             end_path;
  logic             m1_a, m1_b, m2_a, m2_b;
  logic [DC_W-1:0]  dc1, dc2;
  logic             node_flag, node_changed, turn_ack, line_lost;
  logic [2:0]       state;
  modport master (
    output enable, left, middle, right, sample_valid, turn_cmd, turn_valid, end_path,
    input  m1_a, m1_b, m2_a, m2_b, dc1, dc2, node_flag, node_changed, turn_ack, line_lost, state
  );
  modport slave (
    input  enable, left, middle, right, sample_valid, turn_cmd, turn_valid, end_path,
    output m1_a, m1_b, m2_a, m2_b, dc1, dc2, node_flag, node_changed, turn_ack, line_lost, state
  );
endinterface

// File: rtl/lfa_classifier.sv
// lfa_classifier: hysteresis black/white classification per sensor plus node debounce
module lfa_classifier
  import lfc_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int BLACK_TH = 1000,
  parameter int WHITE_TH = 200,
  parameter int NODE_DEB = 4
) (
  input  logic             clk_3125KHz,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] left,
  input  logic [ADC_W-1:0] middle,
  input  logic [ADC_W-1:0] right,
  output logic [2:0]       cls,
  output logic             node_det,
  output logic             node_clr
);
  logic [2:0] cls_q;
  logic [3:0] cnt_q, cnt_d;
  function automatic logic classify(input logic [ADC_W-1:0] v, input logic prev);
    return v > ADC_W'(BLACK_TH) ? B : v < ADC_W'(WHITE_TH) ? W : prev;
  endfunction
  // cls/cnt_d are this cycle's view so the controller reacts on the edge after the sample
  always_comb begin
    cls   = sample_valid ? {classify(left, cls_q[2]), classify(middle, cls_q[1]), classify(right, cls_q[0])} : cls_q;
    cnt_d = !sample_valid ? cnt_q : cls != CLS_BBB ? 4'd0 : cnt_q >= 4'(NODE_DEB) ? cnt_q : cnt_q + 4'd1;
  end
  assign node_det = cnt_d == 4'(NODE_DEB);
  assign node_clr = cnt_d == 4'd0;
  // class and debounce state
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      cls_q <= {W, W, W};
      cnt_q <= 4'd0;
    end else begin
      cls_q <= cls;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: line follower with node handshake, timed turns, lost-line and stop handling
module line_follow_ctrl
  import lfc_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int DC_W     = 5,
  parameter int BLACK_TH = 1000,
  parameter int WHITE_TH = 200,
  parameter int NODE_DEB = 4,
  parameter int TURN_MIN = 3125,
  parameter int LOST_TO  = 31250,
  parameter int DC_BASE  = 10,
  parameter int DC_HI    = 20,
  parameter int DC_LO    = 10,
  parameter int DC_SPIN  = 18,
  parameter int DC_SLOW  = 5
) (
  input logic               clk_3125KHz,
  input logic               reset,
  line_follow_ctrl_if.slave bus
);
  localparam int TW = $clog2(TURN_MIN + 2);
  localparam int LW = $clog2(LOST_TO + 1);
  localparam logic [DC_W-1:0] BASE = DC_W'(DC_BASE);
  localparam logic [DC_W-1:0] HI   = DC_W'(DC_HI);
  localparam logic [DC_W-1:0] LO   = DC_W'(DC_LO);
  localparam logic [DC_W-1:0] SPIN = DC_W'(DC_SPIN);
  localparam logic [DC_W-1:0] SLOW = DC_W'(DC_SLOW);
  logic [2:0]      cls;
  logic            node_det, node_clr, any_b;
  state_t          st_q, st_d;
  logic [1:0]      cmd_q, cmd_d, m1_q, m1_d, m2_q, m2_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [LW-1:0]   lost_q, lost_d;
  logic [DC_W-1:0] dc1_q, dc1_d, dc2_q, dc2_d;
  logic            nc_q, nc_d, ack_q, ack_d;
  lfa_classifier #(
    .ADC_W(ADC_W), .BLACK_TH(BLACK_TH), .WHITE_TH(WHITE_TH), .NODE_DEB(NODE_DEB)
  ) u_cls (
    .clk_3125KHz (clk_3125KHz),
    .reset       (reset),
    .sample_valid(bus.sample_valid),
    .left        (bus.left),
    .middle      (bus.middle),
    .right       (bus.right),
    .cls         (cls),
    .node_det    (node_det),
    .node_clr    (node_clr)
  );
  assign any_b = |cls;
  // next state, then outputs decoded from the next state so they register with it
  always_comb begin
    st_d   = st_q;
    cmd_d  = cmd_q;
    tmr_d  = tmr_q;
    lost_d = '0;
    nc_d   = 1'b0;
    ack_d  = 1'b0;
    m1_d   = DIR_OFF;
    m2_d   = DIR_OFF;
    dc1_d  = '0;
    dc2_d  = '0;
    if (!bus.enable) st_d = IDLE;
    else if (bus.end_path) st_d = STOP;
    else begin
      case (st_q)
        IDLE: st_d = FOLLOW;
        FOLLOW: begin
          if (node_det) st_d = NODE;
          else if (!any_b) begin
            lost_d = lost_q == '1 ? lost_q : lost_q + 1'b1;
            if (lost_q >= LW'(LOST_TO - 1)) st_d = LOST;
          end
        end
        NODE: begin
          if (bus.turn_valid) begin
            cmd_d = bus.turn_cmd;
            ack_d = 1'b1;
            tmr_d = '0;
            st_d  = TURN;
          end
        end
        TURN: begin
          if (tmr_q >= TW'(TURN_MIN) && (cmd_q == T_STRAIGHT ? node_clr : cls == CLS_WBW)) begin
            st_d = FOLLOW;
            nc_d = 1'b1;
          end else tmr_d = tmr_q == '1 ? tmr_q : tmr_q + 1'b1;
        end
        LOST: st_d = bus.sample_valid && any_b ? FOLLOW : LOST;
        default: st_d = IDLE;
      endcase
    end
    case (st_d)
      FOLLOW: begin
        m1_d  = DIR_FWD;
        m2_d  = DIR_FWD;
        dc1_d = cls == CLS_WBW ? BASE : (!cls[2] && cls[0]) ? HI : (cls[2] && !cls[0]) ? LO : dc1_q;
        dc2_d = cls == CLS_WBW ? BASE : (!cls[2] && cls[0]) ? LO : (cls[2] && !cls[0]) ? HI : dc2_q;
      end
      NODE: begin
        m1_d  = DIR_FWD;
        m2_d  = DIR_FWD;
        dc1_d = SLOW;
        dc2_d = SLOW;
      end
      TURN: begin
        m1_d  = cmd_d == T_LEFT ? DIR_REV : DIR_FWD;
        m2_d  = (cmd_d == T_RIGHT || cmd_d == T_UTURN) ? DIR_REV : DIR_FWD;
        dc1_d = cmd_d == T_STRAIGHT ? BASE : cmd_d == T_LEFT ? SLOW : SPIN;
        dc2_d = cmd_d == T_STRAIGHT ? BASE : cmd_d == T_RIGHT ? SLOW : SPIN;
      end
      default: ;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      st_q   <= IDLE;
      cmd_q  <= T_STRAIGHT;
      tmr_q  <= '0;
      lost_q <= '0;
      m1_q   <= DIR_OFF;
      m2_q   <= DIR_OFF;
      dc1_q  <= '0;
      dc2_q  <= '0;
      nc_q   <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cmd_q  <= cmd_d;
      tmr_q  <= tmr_d;
      lost_q <= lost_d;
      m1_q   <= m1_d;
      m2_q   <= m2_d;
      dc1_q  <= dc1_d;
      dc2_q  <= dc2_d;
      nc_q   <= nc_d;
      ack_q  <= ack_d;
    end
  end
  assign {bus.m1_a, bus.m1_b} = m1_q;
  assign {bus.m2_a, bus.m2_b} = m2_q;
  assign bus.dc1          = dc1_q;
  assign bus.dc2          = dc2_q;
  assign bus.node_changed = nc_q;
  assign bus.turn_ack     = ack_q;
  assign bus.node_flag    = st_q == NODE || st_q == TURN;
  assign bus.line_lost    = st_q == LOST;
  assign bus.state        = st_q;
endmodule
